// File: rtl/inst_queue.sv
// Instruction queue between 4-wide fetch and 2-wide decode: compacts valid fetch lanes into a
// circular buffer of {inst, pc} and presents the two oldest entries to decode.
module inst_queue #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      inst_word0,
    input  logic [31:0]      inst_word1,
    input  logic [31:0]      inst_word2,
    input  logic [31:0]      inst_word3,
    input  logic             inst_word0_valid,
    input  logic             inst_word1_valid,
    input  logic             inst_word2_valid,
    input  logic             inst_word3_valid,
    input  logic [31:0]      pc_in0,
    input  logic [31:0]      pc_in1,
    input  logic [31:0]      pc_in2,
    input  logic [31:0]      pc_in3,
    input  logic             flush,
    input  logic [1:0]       deq_count,
    output logic [31:0]      out_inst0,
    output logic [31:0]      out_inst1,
    output logic [31:0]      out_pc0,
    output logic [31:0]      out_pc1,
    output logic             out_valid0,
    output logic             out_valid1,
    output logic             fetch_stall,
    output logic [PTR_W:0]   count,
    output logic             overflow_err
);

    // Two spare bits so DEPTH + n_deq never wraps in the free-space arithmetic.
    localparam int unsigned CW = PTR_W + 2;

    logic [31:0]      mem_inst [DEPTH];
    logic [31:0]      mem_pc   [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr1;

    logic [31:0]      lane_word [4];
    logic [31:0]      lane_pc   [4];
    logic [3:0]       lane_valid;
    logic [3:0]       lane_we;
    logic [2:0]       lane_pos  [4];
    logic [PTR_W-1:0] lane_addr [4];

    logic [1:0]       deq_eff;
    logic [CW-1:0]    cnt_ext;
    logic [CW-1:0]    n_deq;
    logic [CW-1:0]    free_slots;
    logic [CW-1:0]    n_written;
    logic [CW-1:0]    count_next;
    logic [2:0]       pos;
    logic             overflow_set;
    logic             fetch_stall_next;

    assign lane_word[0] = inst_word0;
    assign lane_word[1] = inst_word1;
    assign lane_word[2] = inst_word2;
    assign lane_word[3] = inst_word3;
    assign lane_pc[0]   = pc_in0;
    assign lane_pc[1]   = pc_in1;
    assign lane_pc[2]   = pc_in2;
    assign lane_pc[3]   = pc_in3;
    assign lane_valid   = {inst_word3_valid, inst_word2_valid, inst_word1_valid, inst_word0_valid};

    always_comb begin
        deq_eff    = (deq_count == 2'd3) ? 2'd2 : deq_count;
        cnt_ext    = CW'(count);
        n_deq      = (CW'(deq_eff) > cnt_ext) ? cnt_ext : CW'(deq_eff);
        free_slots = CW'(DEPTH) - cnt_ext + n_deq;

        // Each valid lane lands at wr_ptr + (number of older valid lanes).
        pos       = 3'd0;
        n_written = '0;
        for (int i = 0; i < 4; i++) begin
            lane_pos[i]  = pos;
            lane_addr[i] = wr_ptr + PTR_W'(pos);
            lane_we[i]   = lane_valid[i] && (CW'(pos) < free_slots);
            if (lane_valid[i]) pos = pos + 3'd1;
            if (lane_we[i]) n_written = n_written + CW'(1);
        end

        overflow_set     = |(lane_valid & ~lane_we);
        count_next       = cnt_ext - n_deq + n_written;
        fetch_stall_next = (CW'(DEPTH) - count_next) < CW'(4);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            fetch_stall  <= 1'b0;
            overflow_err <= 1'b0;
        end else if (flush) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fetch_stall <= 1'b0;
        end else begin
            rd_ptr      <= rd_ptr + PTR_W'(n_deq);
            wr_ptr      <= wr_ptr + PTR_W'(n_written);
            count       <= count_next[PTR_W:0];
            fetch_stall <= fetch_stall_next;
            if (overflow_set) overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !flush) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_we[i]) begin
                    mem_inst[lane_addr[i]] <= lane_word[i];
                    mem_pc[lane_addr[i]]   <= lane_pc[i];
                end
            end
        end
    end

    assign rd_ptr1 = rd_ptr + PTR_W'(1);

    always_comb begin
        out_valid0 = (count != '0);
        out_valid1 = (count >= (PTR_W+1)'(2));
        out_inst0  = out_valid0 ? mem_inst[rd_ptr]  : 32'd0;
        out_pc0    = out_valid0 ? mem_pc[rd_ptr]    : 32'd0;
        out_inst1  = out_valid1 ? mem_inst[rd_ptr1] : 32'd0;
        out_pc1    = out_valid1 ? mem_pc[rd_ptr1]   : 32'd0;
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (DEPTH = 8).
module tb_inst_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] inst_word0, inst_word1, inst_word2, inst_word3;
    logic        inst_word0_valid, inst_word1_valid, inst_word2_valid, inst_word3_valid;
    logic [31:0] pc_in0, pc_in1, pc_in2, pc_in3;
    logic        flush;
    logic [1:0]  deq_count;
    logic [31:0] out_inst0, out_inst1, out_pc0, out_pc1;
    logic        out_valid0, out_valid1, fetch_stall, overflow_err;
    logic [3:0]  count;

    int total = 0;
    int bad = 0;

    inst_queue #(.DEPTH(8)) dut (
        .clock(clock), .reset(reset),
        .inst_word0(inst_word0), .inst_word1(inst_word1),
        .inst_word2(inst_word2), .inst_word3(inst_word3),
        .inst_word0_valid(inst_word0_valid), .inst_word1_valid(inst_word1_valid),
        .inst_word2_valid(inst_word2_valid), .inst_word3_valid(inst_word3_valid),
        .pc_in0(pc_in0), .pc_in1(pc_in1), .pc_in2(pc_in2), .pc_in3(pc_in3),
        .flush(flush), .deq_count(deq_count),
        .out_inst0(out_inst0), .out_inst1(out_inst1),
        .out_pc0(out_pc0), .out_pc1(out_pc1),
        .out_valid0(out_valid0), .out_valid1(out_valid1),
        .fetch_stall(fetch_stall), .count(count), .overflow_err(overflow_err)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] wd(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    // Lane i carries pc = base + 4*i.
    task automatic drive(input logic [3:0] mask, input logic [31:0] base,
                         input logic [1:0] deq, input logic fl);
        {inst_word3_valid, inst_word2_valid, inst_word1_valid, inst_word0_valid} = mask;
        pc_in0 = base;       pc_in1 = base + 4;  pc_in2 = base + 8;  pc_in3 = base + 12;
        inst_word0 = wd(pc_in0); inst_word1 = wd(pc_in1);
        inst_word2 = wd(pc_in2); inst_word3 = wd(pc_in3);
        deq_count = deq;
        flush = fl;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(4'h0, 32'h0, 2'd0, 1'b0);
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(4'hF, 32'hDEAD0, 2'd2, 1'b0);
        step();
        reset = 1'b0;
        drive(4'h0, 32'h0, 2'd0, 1'b0);
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", fetch_stall); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow_err); end
        total++; if ({out_valid0, out_valid1} !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b want=00", {out_valid0, out_valid1}); end
        total++; if ({out_inst0, out_pc0, out_inst1, out_pc1} !== 128'd0) begin bad++; $display("FAIL reset_outs got=%h want=0", {out_inst0, out_pc0, out_inst1, out_pc1}); end
    endtask

    task automatic test_fill();
        do_reset();
        drive(4'hF, 32'h100, 2'd0, 1'b0);
        step();
        total++; if (count !== 4'd4) begin bad++; $display("FAIL fill_count4 got=%0d want=4", count); end
        total++; if (out_inst0 !== wd(32'h100)) begin bad++; $display("FAIL fill_inst0 got=%h want=%h", out_inst0, wd(32'h100)); end
        total++; if (out_inst1 !== wd(32'h104)) begin bad++; $display("FAIL fill_inst1 got=%h want=%h", out_inst1, wd(32'h104)); end
        total++; if (out_pc0 !== 32'h100) begin bad++; $display("FAIL fill_pc0 got=%h want=100", out_pc0); end
        total++; if (out_pc1 !== 32'h104) begin bad++; $display("FAIL fill_pc1 got=%h want=104", out_pc1); end
        total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL fill_stall4 got=%b want=0", fetch_stall); end
        drive(4'hF, 32'h110, 2'd0, 1'b0);
        step();
        drive(4'h0, 32'h0, 2'd0, 1'b0);
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_count8 got=%0d want=8", count); end
        total++; if (fetch_stall !== 1'b1) begin bad++; $display("FAIL fill_stall8 got=%b want=1", fetch_stall); end
        total++; if (out_pc0 !== 32'h100) begin bad++; $display("FAIL fill_pc0_8 got=%h want=100", out_pc0); end
    endtask

    task automatic test_compact();
        do_reset();
        drive(4'b1100, 32'h200, 2'd0, 1'b0);
        step();
        drive(4'h0, 32'h0, 2'd0, 1'b0);
        total++; if (count !== 4'd2) begin bad++; $display("FAIL compact_count got=%0d want=2", count); end
        total++; if (out_pc0 !== 32'h208) begin bad++; $display("FAIL compact_pc0 got=%h want=208", out_pc0); end
        total++; if (out_pc1 !== 32'h20C) begin bad++; $display("FAIL compact_pc1 got=%h want=20c", out_pc1); end
        total++; if (out_inst0 !== wd(32'h208)) begin bad++; $display("FAIL compact_inst0 got=%h want=%h", out_inst0, wd(32'h208)); end
    endtask

    task automatic test_deq3();
        do_reset();
        drive(4'b0111, 32'h300, 2'd0, 1'b0);
        step();
        drive(4'h0, 32'h0, 2'd3, 1'b0);
        step();
        total++; if (count !== 4'd1) begin bad++; $display("FAIL deq3_count got=%0d want=1", count); end
        total++; if (out_pc0 !== 32'h308) begin bad++; $display("FAIL deq3_pc0 got=%h want=308", out_pc0); end
        total++; if ({out_valid1, out_pc1} !== 33'd0) begin bad++; $display("FAIL deq3_slot1 got=%h want=0", {out_valid1, out_pc1}); end
        drive(4'h0, 32'h0, 2'd2, 1'b0);
        step();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL deq_under_count got=%0d want=0", count); end
        total++; if ({out_valid0, out_inst0} !== 33'd0) begin bad++; $display("FAIL deq_under_v0 got=%h want=0", {out_valid0, out_inst0}); end
    endtask

    task automatic test_stream();
        logic [31:0] q[$];
        logic [31:0] next_pc;
        logic        push;
        int          n;
        do_reset();
        next_pc = 32'h400;
        for (int cyc = 0; cyc < 20; cyc++) begin
            total++; if (count !== 4'(q.size())) begin bad++; $display("FAIL stream_count c%0d got=%0d want=%0d", cyc, count, q.size()); end
            total++; if (fetch_stall !== ((8 - q.size()) < 4)) begin bad++; $display("FAIL stream_stall c%0d got=%b want=%b", cyc, fetch_stall, (8 - q.size()) < 4); end
            if (q.size() >= 1) begin
                total++; if (out_pc0 !== q[0]) begin bad++; $display("FAIL stream_pc0 c%0d got=%h want=%h", cyc, out_pc0, q[0]); end
            end
            if (q.size() >= 2) begin
                total++; if (out_pc1 !== q[1]) begin bad++; $display("FAIL stream_pc1 c%0d got=%h want=%h", cyc, out_pc1, q[1]); end
            end
            push = !fetch_stall;
            drive(push ? 4'hF : 4'h0, next_pc, 2'd2, 1'b0);
            n = (q.size() < 2) ? q.size() : 2;
            repeat (n) void'(q.pop_front());
            if (push) begin
                for (int i = 0; i < 4; i++) q.push_back(next_pc + 32'(4 * i));
                next_pc = next_pc + 32'd16;
            end
            step();
        end
        drive(4'h0, 32'h0, 2'd0, 1'b0);
        total++; if (count !== 4'(q.size())) begin bad++; $display("FAIL stream_final_count got=%0d want=%0d", count, q.size()); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL stream_ovf got=%b want=0", overflow_err); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(4'hF, 32'h500, 2'd0, 1'b0);
        step();
        drive(4'b0011, 32'h510, 2'd0, 1'b0);
        step();
        total++; if (count !== 4'd6) begin bad++; $display("FAIL flush_pre_count got=%0d want=6", count); end
        drive(4'hF, 32'h600, 2'd2, 1'b1);
        step();
        drive(4'h0, 32'h0, 2'd0, 1'b0);
        total++; if (count !== 4'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", count); end
        total++; if ({out_valid0, out_pc0} !== 33'd0) begin bad++; $display("FAIL flush_v0 got=%h want=0", {out_valid0, out_pc0}); end
        total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", fetch_stall); end
        drive(4'b0001, 32'h700, 2'd0, 1'b0);
        step();
        drive(4'h0, 32'h0, 2'd0, 1'b0);
        total++; if (count !== 4'd1) begin bad++; $display("FAIL flush_after_count got=%0d want=1", count); end
        total++; if (out_pc0 !== 32'h700) begin bad++; $display("FAIL flush_after_pc0 got=%h want=700", out_pc0); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL flush_ovf got=%b want=0", overflow_err); end
    endtask

    task automatic test_overflow();
        do_reset();
        drive(4'hF, 32'h800, 2'd0, 1'b0);
        step();
        drive(4'b0011, 32'h810, 2'd0, 1'b0);
        step();
        drive(4'hF, 32'h900, 2'd0, 1'b0);
        step();
        total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d want=8", count); end
        total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow_err); end
        // Full queue: dequeue 2 frees exactly 2 slots for this cycle's lanes.
        drive(4'hF, 32'hA00, 2'd2, 1'b0);
        step();
        total++; if (count !== 4'd8) begin bad++; $display("FAIL full_swap_count got=%0d want=8", count); end
        total++; if (out_pc0 !== 32'h808) begin bad++; $display("FAIL full_swap_pc0 got=%h want=808", out_pc0); end
        drive(4'h0, 32'h0, 2'd2, 1'b0);
        step();
        step();
        total++; if (out_pc0 !== 32'h900 || out_pc1 !== 32'h904) begin bad++; $display("FAIL ovf_kept got=%h/%h want=900/904", out_pc0, out_pc1); end
        step();
        total++; if (count !== 4'd2) begin bad++; $display("FAIL full_swap_tail_count got=%0d want=2", count); end
        total++; if (out_pc0 !== 32'hA00 || out_pc1 !== 32'hA04) begin bad++; $display("FAIL full_swap_tail got=%h/%h want=a00/a04", out_pc0, out_pc1); end
        total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow_err); end
        do_reset();
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow_err); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL ovf_reset_count got=%0d want=0", count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_compact();
        test_deq3();
        test_stream();
        test_flush();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
